// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decode between IF/ID and ID/EX.
// Splits the instruction into fields, zeroes the fields its format does not use,
// builds the sign-extended immediate and operand-use flags, and flags illegal
// encodings. The result sits in a one-entry register with valid/ready, stall and flush.
// Optional feature: define DECODE_PERF_CNT_EN to add the perf_decoded / perf_stall counters.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       imm,
  output logic                  rs1_used,
  output logic                  rs2_used,
  output logic                  rd_we,
`ifdef DECODE_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] perf_decoded,
  output logic [PERF_CNT_W-1:0] perf_stall,
`endif
  output logic                  illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // Immediates per format, each sign-extended from its own top bit.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));

  logic            capture;
  logic [2:0]      d_func3;
  logic [6:0]      d_func7;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm;
  logic            d_rs1_used, d_rs2_used, d_rd_we, d_illegal;

  // Accept only when not flushing and the held entry is empty or draining now.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  // Combinational field extraction; unused fields stay zero.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    d_func3    = '0;
    d_func7    = '0;
    d_rs1      = '0;
    d_rs2      = '0;
    d_rd       = '0;
    d_imm      = '0;
    d_rs1_used = 1'b0;
    d_rs2_used = 1'b0;
    d_rd_we    = 1'b0;
    d_illegal  = 1'b0;
    // Every legal opcode ends in 2'b11, so bad low bits fall to the default arm.
    case (in_instr[6:0])
      OP_R: begin
        if (in_instr[31:25] == 7'b0000000 || in_instr[31:25] == 7'b0100000 ||
            in_instr[31:25] == 7'b0000001) begin
          d_func3    = in_instr[14:12];
          d_func7    = in_instr[31:25];
          d_rs1      = in_instr[19:15];
          d_rs2      = in_instr[24:20];
          d_rd       = in_instr[11:7];
          d_rs1_used = 1'b1;
          d_rs2_used = 1'b1;
          d_rd_we    = |in_instr[11:7];
        end else begin
          d_illegal  = 1'b1;
        end
      end
      OP_I, OP_LOAD, OP_JALR: begin
        if (in_instr[6:0] != OP_JALR || in_instr[14:12] == 3'b000) begin
          d_func3    = in_instr[14:12];
          d_rs1      = in_instr[19:15];
          d_rd       = in_instr[11:7];
          d_imm      = imm_i;
          d_rs1_used = 1'b1;
          d_rd_we    = |in_instr[11:7];
        end else begin
          d_illegal  = 1'b1;
        end
      end
      OP_S, OP_B: begin
        d_func3    = in_instr[14:12];
        d_rs1      = in_instr[19:15];
        d_rs2      = in_instr[24:20];
        d_imm      = (in_instr[6:0] == OP_S) ? imm_s : imm_b;
        d_rs1_used = 1'b1;
        d_rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        d_rd    = in_instr[11:7];
        d_imm   = imm_u;
        d_rd_we = |in_instr[11:7];
      end
      OP_JAL: begin
        d_rd    = in_instr[11:7];
        d_imm   = imm_j;
        d_rd_we = |in_instr[11:7];
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Valid bit: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!rst_n)          out_valid <= 1'b0;
    else if (flush)      out_valid <= 1'b0;
    else if (capture)    out_valid <= 1'b1;
    else if (out_ready)  out_valid <= 1'b0;
  end

  // Payload register: loads only on capture, so a stall freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc   <= '0;
      opcode   <= '0;
      func3    <= '0;
      func7    <= '0;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      imm      <= '0;
      rs1_used <= 1'b0;
      rs2_used <= 1'b0;
      rd_we    <= 1'b0;
      illegal  <= 1'b0;
    end else if (capture) begin
      out_pc   <= in_pc;
      opcode   <= in_instr[6:0];
      func3    <= d_func3;
      func7    <= d_func7;
      rs1      <= d_rs1;
      rs2      <= d_rs2;
      rd       <= d_rd;
      imm      <= d_imm;
      rs1_used <= d_rs1_used;
      rs2_used <= d_rs2_used;
      rd_we    <= d_rd_we;
      illegal  <= d_illegal;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Free-running wrap-around counters of captures and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
    end else begin
      if (capture)                perf_decoded <= perf_decoded + 1'b1;
      if (out_valid && !out_ready) perf_stall  <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed stimulus against a format-table reference model.
module tb_decode_stage;

  localparam int XLEN       = 32;
  localparam int PERF_CNT_W = 32;

  logic                  clk, rst_n;
  logic                  in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc, out_pc, imm;
  logic [6:0]            opcode, func7;
  logic [2:0]            func3;
  logic [4:0]            rs1, rs2, rd;
  logic                  rs1_used, rs2_used, rd_we, illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_decoded, perf_stall;
`endif

  decode_stage #(.XLEN(XLEN), .PERF_CNT_W(PERF_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .opcode(opcode), .func3(func3),
    .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we),
`ifdef DECODE_PERF_CNT_EN
    .perf_decoded(perf_decoded), .perf_stall(perf_stall),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the held entry should contain.
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        rs1u, rs2u, rdwe, ill;
  } dec_t;

  dec_t                  m_dec;
  logic                  m_valid;
  logic [PERF_CNT_W-1:0] m_perf_dec, m_perf_stall;

  // Decode by first naming the format, then applying which fields that format owns.
  function automatic dec_t ref_decode(input logic [31:0] i, input logic [63:0] pc);
    dec_t d;
    byte fmt;
    longint v;
    logic [XLEN-1:0] t;
    d = '0;
    d.pc = pc;
    d.opcode = i[6:0];
    v = 0;
    case (i[6:0])
      7'b0110011: fmt = (i[31:25] inside {7'h00, 7'h20, 7'h01}) ? "R" : "x";
      7'b0010011, 7'b0000011: fmt = "I";
      7'b1100111: fmt = (i[14:12] == 3'd0) ? "I" : "x";
      7'b0100011: fmt = "S";
      7'b1100011: fmt = "B";
      7'b0110111, 7'b0010111: fmt = "U";
      7'b1101111: fmt = "J";
      default:    fmt = "x";
    endcase
    if (fmt == "x") begin
      d.ill = 1'b1;
      return d;
    end
    case (fmt)
      "I": v = longint'($signed(i[31:20]));
      "S": v = longint'($signed({i[31:25], i[11:7]}));
      "B": v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      "U": v = longint'($signed({i[31:12], 12'h000}));
      "J": v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: v = 0;
    endcase
    t = v[XLEN-1:0];
    d.imm  = 64'(t);
    d.rs1u = fmt inside {"R", "I", "S", "B"};
    d.rs2u = fmt inside {"R", "S", "B"};
    if (d.rs1u) d.rs1 = i[19:15];
    if (d.rs2u) d.rs2 = i[24:20];
    if (fmt inside {"R", "I", "S", "B"}) d.f3 = i[14:12];
    if (fmt == "R") d.f7 = i[31:25];
    if (fmt inside {"R", "I", "U", "J"}) d.rd = i[11:7];
    d.rdwe = (d.rd != 5'd0);
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_dec = '0;
    m_perf_dec = '0;
    m_perf_stall = '0;
  endtask

  task automatic check_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_opcode", opcode, 0);
    check("rst_func3", func3, 0);
    check("rst_func7", func7, 0);
    check("rst_regs", {rs1, rs2, rd}, 0);
    check("rst_imm", imm, 0);
    check("rst_flags", {rs1_used, rs2_used, rd_we, illegal}, 0);
`ifdef DECODE_PERF_CNT_EN
    check("rst_perf", {perf_decoded, perf_stall}, 0);
`endif
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_pc", out_pc, m_dec.pc);
      check("opcode", opcode, m_dec.opcode);
      check("func3", func3, m_dec.f3);
      check("func7", func7, m_dec.f7);
      check("rs1", rs1, m_dec.rs1);
      check("rs2", rs2, m_dec.rs2);
      check("rd", rd, m_dec.rd);
      check("imm", imm, m_dec.imm);
      check("rs1_used", rs1_used, m_dec.rs1u);
      check("rs2_used", rs2_used, m_dec.rs2u);
      check("rd_we", rd_we, m_dec.rdwe);
      check("illegal", illegal, m_dec.ill);
    end
`ifdef DECODE_PERF_CNT_EN
    check("perf_decoded", perf_decoded, m_perf_dec);
    check("perf_stall", perf_stall, m_perf_stall);
`endif
  endtask

  // One clock: drive at the falling edge, check in_ready, advance the model, check outputs.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic fl, input logic rdy);
    logic exp_ready, cap, stalled;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc[XLEN-1:0];
    flush     = fl;
    out_ready = rdy;
    exp_ready = !fl && (!m_valid || rdy);
    cap       = v && exp_ready;
    stalled   = m_valid && !rdy;
    #1;
    check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (fl)        m_valid = 1'b0;
    else if (cap)  m_valid = 1'b1;
    else if (rdy)  m_valid = 1'b0;
    if (cap) m_dec = ref_decode(ins, 64'(pc[XLEN-1:0]));
    m_perf_dec   = m_perf_dec + PERF_CNT_W'(cap);
    m_perf_stall = m_perf_stall + PERF_CNT_W'(stalled);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [0:8];
    logic [6:0] f7s [0:3];
    logic [31:0] w;
    int sel;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h7F};
    w = $urandom;
    sel = $urandom_range(0, 11);
    if (sel <= 8) w[6:0] = ops[sel];
    if (sel == 10) begin
      w[6:0] = 7'b0110011;
      w[31:25] = f7s[$urandom_range(0, 3)];
    end
    if (sel == 11) w[1:0] = 2'($urandom_range(0, 2));
    if (w[6:0] == 7'b1100111 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  logic [63:0] rpc;

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset();
    @(negedge clk);

    // addi x1,x0,5
    cycle(1, 32'h00500093, 64'h100, 0, 1);
    check("addi_rd", rd, 1);
    check("addi_imm", imm, 5);
    check("addi_rd_we", rd_we, 1);
    check("addi_rs2_used", rs2_used, 0);

    // bne x1,x2,-4
    cycle(1, 32'hFE209EE3, 64'h104, 0, 1);
    check("bne_rs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd0});
    check("bne_imm", imm, 64'({{(XLEN-3){1'b1}}, 3'b100}));
    check("bne_rd_we", rd_we, 0);

    // Back-to-back, then two stall cycles, then drain.
    cycle(1, 32'h00208133, 64'h108, 0, 1);
    cycle(1, 32'h0000A183, 64'h10C, 0, 1);
    cycle(1, 32'h00312223, 64'h110, 0, 1);
    cycle(1, 32'h123452B7, 64'h114, 0, 0);
    cycle(1, 32'h0080006F, 64'h118, 0, 0);
    check("stall_in_ready", in_ready, 0);
    cycle(0, 32'h0, 64'h0, 0, 1);

    // Flush while holding an entry and offering a new one.
    cycle(1, 32'h00500093, 64'h200, 0, 0);
    cycle(1, 32'h00A00113, 64'h204, 1, 0);
    check("flush_out_valid", out_valid, 0);

    // Unsupported opcode.
    cycle(1, 32'h0000007F, 64'h300, 0, 1);
    check("ill_flag", illegal, 1);
    check("ill_imm", imm, 0);
    check("ill_rd_we", rd_we, 0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rpc = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), rpc,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset while stalled.
    cycle(1, 32'h00500093, 64'h400, 0, 0);
    cycle(0, 32'h0, 64'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    cycle(1, 32'h00500093, 64'h500, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
